axi_slave_mem: RTL and testbench

//  AXI4 slave responder that terminates full AXI4 read/write transactions into a local

---
 rtl/axi_slave_mem.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave that terminates read/write bursts into a local register-array
// memory. Independent write and read engines, FIXED/INCR bursts, OKAY/SLVERR responses.
module axi_slave_mem #(
    parameter int ADDR_W    = 40,
    parameter int ID_W      = 16,
    parameter int DATA_W    = 128,
    parameter int MEM_DEPTH = 256
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_aresetn,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int SIZE_LOG = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(MEM_DEPTH);

    localparam logic [ADDR_W-1:0] MEM_BYTES  = ADDR_W'(MEM_DEPTH * STRB_W);
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(STRB_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRB_W - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // A beat is serviceable only if it lands inside the array, uses full-width beats,
    // and belongs to a burst type we implement (WRAP and reserved are rejected).
    function automatic logic beat_ok(input logic [ADDR_W-1:0] addr,
                                     input logic [2:0]        size,
                                     input logic [1:0]        burst);
        return (addr < MEM_BYTES) && (size == 3'(SIZE_LOG)) &&
               ((burst == BURST_FIXED) || (burst == BURST_INCR));
    endfunction

    // INCR aligns the start down to a beat boundary before stepping; FIXED stays put.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [1:0]        burst);
        return (burst == BURST_INCR) ? ((addr & ALIGN_MASK) + BEAT_BYTES) : addr;
    endfunction

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    w_state_t          w_state;
    logic [ADDR_W-1:0] w_addr;
    logic [ID_W-1:0]   w_id;
    logic [7:0]        w_len;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic [7:0]        w_cnt;
    logic              w_err;

    r_state_t          r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [7:0]        r_cnt;

    logic              w_fire;
    logic              w_beat_ok;
    logic              w_is_last;
    logic              w_beat_err;

    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        rd_size;
    logic [1:0]        rd_burst;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_word;

    assign w_fire     = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready;
    assign w_beat_ok  = beat_ok(w_addr, w_size, w_burst);
    assign w_is_last  = (w_cnt == w_len);
    assign w_beat_err = !w_beat_ok || (s_axi_wlast != w_is_last);

    // Select the beat the read engine will load next: beat 0 straight from the AR channel,
    // later beats from the stepped burst address.
    always_comb begin
        rd_addr  = next_addr(r_addr, r_burst);
        rd_size  = r_size;
        rd_burst = r_burst;
        if (r_state == R_IDLE) begin
            rd_addr  = s_axi_araddr;
            rd_size  = s_axi_arsize;
            rd_burst = s_axi_arburst;
        end
        rd_ok   = beat_ok(rd_addr, rd_size, rd_burst);
        rd_word = mem[rd_addr[SIZE_LOG +: IDX_W]];
    end

    // Byte-masked memory write; contents survive reset so the array is never cleared.
    always_ff @(posedge s_axi_aclk) begin
        if (w_fire && w_beat_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_addr[SIZE_LOG +: IDX_W]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Write engine: accept AW, consume exactly awlen+1 beats, then hold B until taken.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_bid     <= '0;
            w_addr        <= '0;
            w_id          <= '0;
            w_len         <= '0;
            w_size        <= '0;
            w_burst       <= '0;
            w_cnt         <= '0;
            w_err         <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_axi_awready && s_axi_awvalid) begin
                        w_addr        <= s_axi_awaddr;
                        w_id          <= s_axi_awid;
                        w_len         <= s_axi_awlen;
                        w_size        <= s_axi_awsize;
                        w_burst       <= s_axi_awburst;
                        w_cnt         <= '0;
                        w_err         <= 1'b0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_DATA;
                    end else begin
                        s_axi_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (w_is_last) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bid    <= w_id;
                            s_axi_bresp  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state      <= W_RESP;
                        end else begin
                            w_cnt  <= w_cnt + 8'd1;
                            w_addr <= next_addr(w_addr, w_burst);
                            w_err  <= w_err || w_beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read engine: accept AR, present one beat at a time, advance only when the beat is taken.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rid     <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arready && s_axi_arvalid) begin
                        r_addr        <= s_axi_araddr;
                        r_len         <= s_axi_arlen;
                        r_size        <= s_axi_arsize;
                        r_burst       <= s_axi_arburst;
                        r_cnt         <= '0;
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rid     <= s_axi_arid;
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        s_axi_rdata   <= rd_ok ? rd_word : '0;
                        s_axi_rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        r_state       <= R_DATA;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_cnt       <= r_cnt + 8'd1;
                            r_addr      <= rd_addr;
                            s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
                            s_axi_rdata <= rd_ok ? rd_word : '0;
                            s_axi_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed bench for axi_slave_mem covering bursts, strobes, error
// responses, back-pressure on R and B, and reset in the middle of a write burst.
`timescale 1ns/1ps
module tb_axi_slave_mem;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [39:0]   s_axi_awaddr = '0;
    logic [15:0]   s_axi_awid = '0;
    logic [7:0]    s_axi_awlen = '0;
    logic [2:0]    s_axi_awsize = '0;
    logic [1:0]    s_axi_awburst = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [127:0]  s_axi_wdata = '0;
    logic [15:0]   s_axi_wstrb = '0;
    logic          s_axi_wlast = 1'b0;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic [15:0]   s_axi_bid;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b0;
    logic [39:0]   s_axi_araddr = '0;
    logic [15:0]   s_axi_arid = '0;
    logic [7:0]    s_axi_arlen = '0;
    logic [2:0]    s_axi_arsize = '0;
    logic [1:0]    s_axi_arburst = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [127:0]  s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic [15:0]   s_axi_rid;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b0;

    int checks = 0;
    int errors = 0;

    axi_slave_mem #(
        .ADDR_W(40), .ID_W(16), .DATA_W(128), .MEM_DEPTH(256)
    ) dut (
        .s_axi_aclk(clk),
        .s_axi_aresetn(rst_n),
        .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awid(s_axi_awid),
        .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_bid(s_axi_bid),
        .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr),
        .s_axi_arid(s_axi_arid),
        .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp),
        .s_axi_rid(s_axi_rid),
        .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready)
    );

    // 100 MHz clock; the bench drives and samples on the falling edge.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checkOutput(tag, 128'(observed), 128'(expected));
    endtask

    task automatic applyWrite(input logic [39:0] addr, input logic [15:0] id,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [127:0] data0,
                              input logic [15:0] strb, input int early, input int hold,
                              input logic [1:0] exp_resp);
        int n;
        s_axi_awaddr  = addr;
        s_axi_awid    = id;
        s_axi_awlen   = len;
        s_axi_awsize  = size;
        s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        n = 0;
        while (s_axi_awready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkBit("awready", s_axi_awready, 1'b1);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wdata  = data0 + 128'(i);
            s_axi_wstrb  = strb;
            s_axi_wlast  = (i == int'(len)) || (i == early);
            s_axi_wvalid = 1'b1;
            n = 0;
            while (s_axi_wready !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            checkBit("wready", s_axi_wready, 1'b1);
            @(negedge clk);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        checkBit("b_latency", s_axi_bvalid, 1'b1);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            checkBit("b_hold_valid", s_axi_bvalid, 1'b1);
            checkOutput("b_hold_id", 128'(s_axi_bid), 128'(id));
            checkOutput("b_hold_resp", 128'(s_axi_bresp), 128'(exp_resp));
        end
        checkOutput("bid", 128'(s_axi_bid), 128'(id));
        checkOutput("bresp", 128'(s_axi_bresp), 128'(exp_resp));
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        checkBit("b_done", s_axi_bvalid, 1'b0);
        checkBit("aw_rearm", s_axi_awready, 1'b1);
    endtask

    task automatic applyRead(input logic [39:0] addr, input logic [15:0] id,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [127:0] exp0,
                             input logic [1:0] exp_resp, input logic stall);
        int n;
        int stalls;
        logic [127:0] exp;
        s_axi_araddr  = addr;
        s_axi_arid    = id;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (s_axi_arready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkBit("arready", s_axi_arready, 1'b1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            exp = exp0 + 128'(i);
            stalls = stall ? int'($urandom_range(0, 2)) : 0;
            for (int s = 0; s < stalls; s++) begin
                s_axi_rready = 1'b0;
                @(negedge clk);
                checkBit("r_stall_valid", s_axi_rvalid, 1'b1);
                checkOutput("r_stall_data", s_axi_rdata, exp);
                checkBit("r_stall_last", s_axi_rlast, i == int'(len));
            end
            s_axi_rready = 1'b1;
            checkBit("rvalid", s_axi_rvalid, 1'b1);
            checkOutput("rdata", s_axi_rdata, exp);
            checkOutput("rresp", 128'(s_axi_rresp), 128'(exp_resp));
            checkOutput("rid", 128'(s_axi_rid), 128'(id));
            checkBit("rlast", s_axi_rlast, i == int'(len));
            @(negedge clk);
        end
        s_axi_rready = 1'b0;
        checkBit("r_done", s_axi_rvalid, 1'b0);
        checkBit("ar_rearm", s_axi_arready, 1'b1);
    endtask

    // Directed sequence: reset, bursts, strobes, errors, back-pressure, mid-burst reset.
    initial begin
        int n;
        repeat (3) @(negedge clk);
        checkBit("rst_awready", s_axi_awready, 1'b0);
        checkBit("rst_arready", s_axi_arready, 1'b0);
        checkBit("rst_wready", s_axi_wready, 1'b0);
        checkBit("rst_bvalid", s_axi_bvalid, 1'b0);
        checkBit("rst_rvalid", s_axi_rvalid, 1'b0);
        checkBit("rst_rlast", s_axi_rlast, 1'b0);
        checkOutput("rst_rdata", s_axi_rdata, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkBit("rel_awready", s_axi_awready, 1'b1);
        checkBit("rel_arready", s_axi_arready, 1'b1);

        $display("[TB] INCR write/read burst");
        applyWrite(40'h100, 16'h1234, 8'd3, 3'd4, INCR, 128'hA0, 16'hFFFF, -1, 0, OKAY);
        applyRead(40'h100, 16'h5678, 8'd3, 3'd4, INCR, 128'hA0, OKAY, 1'b0);

        $display("[TB] byte strobes");
        applyWrite(40'h0, 16'h0001, 8'd0, 3'd4, INCR, 128'h0, 16'hFFFF, -1, 0, OKAY);
        applyWrite(40'h0, 16'h0002, 8'd0, 3'd4, INCR, {128{1'b1}}, 16'h000F, -1, 0, OKAY);
        applyRead(40'h0, 16'h0003, 8'd0, 3'd4, INCR, 128'hFFFF_FFFF, OKAY, 1'b0);

        $display("[TB] error responses");
        applyWrite(40'h1000, 16'h0004, 8'd0, 3'd4, INCR, 128'h5555, 16'hFFFF, -1, 0, SLVERR);
        applyRead(40'h0, 16'h0005, 8'd0, 3'd4, INCR, 128'hFFFF_FFFF, OKAY, 1'b0);
        applyRead(40'h100, 16'h0006, 8'd0, 3'd2, INCR, 128'h0, SLVERR, 1'b0);
        applyWrite(40'h300, 16'h0007, 8'd2, 3'd4, INCR, 128'hD0, 16'hFFFF, 1, 0, SLVERR);

        $display("[TB] back-pressure");
        applyWrite(40'h400, 16'h0008, 8'd7, 3'd4, INCR, 128'hB0, 16'hFFFF, -1, 10, OKAY);
        applyRead(40'h400, 16'h0009, 8'd7, 3'd4, INCR, 128'hB0, OKAY, 1'b1);

        $display("[TB] FIXED burst");
        applyWrite(40'h500, 16'h000A, 8'd1, 3'd4, FIXED, 128'hC0, 16'hFFFF, -1, 0, OKAY);
        applyRead(40'h500, 16'h000B, 8'd0, 3'd4, INCR, 128'hC1, OKAY, 1'b0);

        $display("[TB] reset during 16-beat write");
        s_axi_awaddr  = 40'h600;
        s_axi_awid    = 16'h00EE;
        s_axi_awlen   = 8'd15;
        s_axi_awsize  = 3'd4;
        s_axi_awburst = INCR;
        s_axi_awvalid = 1'b1;
        n = 0;
        while (s_axi_awready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkBit("mid_awready", s_axi_awready, 1'b1);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_axi_wdata  = 128'hE0 + 128'(i);
            s_axi_wstrb  = 16'hFFFF;
            s_axi_wlast  = 1'b0;
            s_axi_wvalid = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checkBit("mid_rst_wready", s_axi_wready, 1'b0);
        checkBit("mid_rst_awready", s_axi_awready, 1'b0);
        checkBit("mid_rst_bvalid", s_axi_bvalid, 1'b0);
        checkBit("mid_rst_rvalid", s_axi_rvalid, 1'b0);
        s_axi_wvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkBit("post_rst_awready", s_axi_awready, 1'b1);
        applyWrite(40'h600, 16'h000C, 8'd0, 3'd4, INCR, 128'hF0, 16'hFFFF, -1, 0, OKAY);
        applyRead(40'h600, 16'h000D, 8'd0, 3'd4, INCR, 128'hF0, OKAY, 1'b0);
        applyRead(40'h610, 16'h000E, 8'd0, 3'd4, INCR, 128'hE1, OKAY, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
